muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer. It owns the write port of the HI/LO register pair.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
//  - Runs a 32-step iterative shift-add multiply or restoring divide.
//  - Drives the HiLo inputs dinHi/dinLo/hlWrite and stalls the pipeline while busy.
// PARAMETERS
//  WIDTH  32  operand width; the iteration count equals WIDTH.
// PORTS
//  clk      in   1      clock; all state updates on the rising edge
//  rst      in   1      reset, synchronous, active-high
//  start    in   1      issue request; sampled only in IDLE
//  op       in   3      op code: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  srcA     in   WIDTH  rs: multiplicand/dividend; MTHI/MTLO data
//  srcB     in   WIDTH  rt: multiplier/divisor
//  flush    in   1      cancels any in-flight op; no HI/LO write
//  dinHi    out  WIDTH  data for HI
//  dinLo    out  WIDTH  data for LO
//  hlWrite  out  2      HI/LO write strobes; [1] writes HI, [0] writes LO
//  busy     out  1      registered; high while an op occupies the unit
//  stall    out  1      combinational: busy | (start & op is mul/div & state==IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, count=0, busy=0, hlWrite=2'b00, dinHi=dinLo=0. Accumulators are cleared.
//  FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE, start with mul/div op:
//    - capture |srcA| and |srcB| for signed ops, or raw values for unsigned ops;
//    - latch the sign flags;
//    - go to CALC with count=0 and busy=1.
//  - IDLE, start with MTHI/MTLO: no state change and busy stays 0.
//    - Next cycle: dinHi/dinLo=srcA and hlWrite=2'b10 (MTHI) or 2'b01 (MTLO) for one cycle.
//  - CALC: one iteration per cycle. After 32 cycles (count==WIDTH-1), go to DONE.
//  - DONE: hlWrite=2'b11 for exactly one cycle with the final result; busy=1; then IDLE, busy=0.
//  Latency: sampling start at edge E0 puts hlWrite high in the 33rd cycle after E0. HiLo captures it at edge E0+33.
//  MULT/MULTU results: {hi,lo} = 64-bit product.
//  - Signed: product of magnitudes, two's-complement negated when the operand signs differ.
//  - -2^31 has magnitude 2^31, which fits as unsigned.
//  DIV/DIVU results: lo=quotient, hi=remainder.
//  - Signed: quotient negated if the signs differ; remainder takes the sign of the dividend.
//  Divide by zero is defined, not X:
//  - unsigned: lo=32'hFFFF_FFFF, hi=srcA;
//  - signed: restoring result on magnitudes, then the sign fix above.
//  start while busy: ignored; no queueing, and the pipeline is stalled anyway.
//  flush or rst in CALC or DONE: next state IDLE, busy=0, hlWrite=0. HI/LO are untouched.
//  - flush and start in the same IDLE cycle: flush wins and nothing is issued.
//  Unknown op code with start: treated as a no-op and stays IDLE.
//  hlWrite is 2'b00 in every cycle not listed above.
// STRUCTURE
//  Shared package (muldiv_pkg):
//  - op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
//  - FSM state encodings;
//  - the hlWrite masks HL_HI=2'b10, HL_LO=2'b01, HL_BOTH=2'b11.
//  One sub-module, muldiv_iter: the WIDTH-step datapath.
//  - Holds a 2*WIDTH accumulator and a WIDTH operand register.
//  - mode input selects shift-add vs restore-subtract; exposes result_hi/result_lo.
//  The top level holds the FSM, the counter, sign handling and the output registers.
// TESTING (bench drives clk 20ns period, checks HiLo contents after each write)
//  1. MULTU srcA=FFFF_FFFF srcB=FFFF_FFFF -> hlWrite=11 at cycle 33: hi=FFFF_FFFE, lo=0000_0001.
//  2. MULT srcA=FFFF_FFFD(-3) srcB=5 -> hi=FFFF_FFFF, lo=FFFF_FFF1; busy high for 33 cycles.
//  3. DIV srcA=FFFF_FFF9(-7) srcB=2 -> lo=FFFF_FFFD(-3), hi=FFFF_FFFF(-1).
//     DIVU 7/0 -> lo=FFFF_FFFF, hi=0000_0007.
//  4. MTHI srcA=1111_1111, then MTLO srcA=2222_2222 on the next cycle.
//     -> hlWrite=10 then 01 on consecutive cycles; HI=1111_1111, LO=2222_2222; busy stays 0.
//  5. Preload HI/LO=AAAA_AAAA; DIVU 100/3, flush at cycle 10.
//     -> no hlWrite; HI/LO still AAAA_AAAA; busy=0 next cycle.
//     -> new MULTU 3*4 then gives lo=0000_000C, hi=0.
//  6. MULTU 2*3 running, start DIVU 9/3 at cycle 5 -> second request ignored: only lo=6, hi=0 written.
//     -> rst at cycle 20 of a new MULT: all outputs 0 next cycle, no write.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states,
// HI/LO write masks and small op-classification helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_HI   = 2'b10;
  localparam logic [1:0] HL_LO   = 2'b01;
  localparam logic [1:0] HL_BOTH = 2'b11;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// WIDTH-step iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. Results reflect the accumulator after this cycle's step.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             mul_i,
  input  logic [WIDTH-1:0] opnd_a_i,
  input  logic [WIDTH-1:0] opnd_b_i,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               mul_q;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;

  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    // When the subtract succeeds the true difference is below 2^WIDTH.
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    if (mul_q) begin
      acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end else if (rem_ge) begin
      acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign result_hi_o = acc_d[2*WIDTH-1:WIDTH];
  assign result_lo_o = acc_d[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mul_q  <= 1'b0;
    end else if (load_i) begin
      mul_q  <= mul_i;
      opnd_q <= mul_i ? opnd_a_i : opnd_b_i;
      acc_q  <= {{WIDTH{1'b0}}, (mul_i ? opnd_b_i : opnd_a_i)};
    end else if (step_i) begin
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO write port.
// state  | meaning
// S_IDLE | accepting ops; MTHI/MTLO handled here in one cycle
// S_CALC | WIDTH iterations of the datapath
// S_DONE | final result presented with hl_write=11
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] din_hi_o,
  output logic [WIDTH-1:0] din_lo_o,
  output logic [1:0]       hl_write_o,
  output logic             busy_o,
  output logic             stall_o
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic [1:0]       hl_write_q;
  logic [WIDTH-1:0] din_hi_q, din_lo_q;
  logic             sign_a_q, sign_b_q, mul_q;

  logic             issue_md, step, sign_a_in, sign_b_in;
  logic [WIDTH-1:0] mag_a, mag_b, iter_hi, iter_lo, res_hi_d, res_lo_d;

  always_comb begin
    issue_md  = (state_q == S_IDLE) && start_i && !flush_i && is_muldiv(op_i);
    step      = (state_q == S_CALC) && !flush_i;
    sign_a_in = is_signed_op(op_i) & src_a_i[WIDTH-1];
    sign_b_in = is_signed_op(op_i) & src_b_i[WIDTH-1];
    mag_a     = sign_a_in ? -src_a_i : src_a_i;
    mag_b     = sign_b_in ? -src_b_i : src_b_i;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (issue_md),
    .step_i      (step),
    .mul_i       (is_mul(op_i)),
    .opnd_a_i    (mag_a),
    .opnd_b_i    (mag_b),
    .result_hi_o (iter_hi),
    .result_lo_o (iter_lo)
  );

  // Sign fix: remainder follows the dividend, quotient/product follow sign_a ^ sign_b.
  always_comb begin
    res_hi_d = iter_hi;
    res_lo_d = iter_lo;
    if (mul_q) begin
      if (sign_a_q ^ sign_b_q) {res_hi_d, res_lo_d} = -{iter_hi, iter_lo};
    end else begin
      if (sign_a_q ^ sign_b_q) res_lo_d = -iter_lo;
      if (sign_a_q)            res_hi_d = -iter_hi;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      busy_q     <= 1'b0;
      hl_write_q <= HL_NONE;
      din_hi_q   <= '0;
      din_lo_q   <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      mul_q      <= 1'b0;
    end else begin
      hl_write_q <= HL_NONE;
      case (state_q)
        S_IDLE: begin
          if (issue_md) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            count_q  <= '0;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            mul_q    <= is_mul(op_i);
          end else if (start_i && !flush_i && (op_i == OP_MTHI || op_i == OP_MTLO)) begin
            din_hi_q   <= src_a_i;
            din_lo_q   <= src_a_i;
            hl_write_q <= (op_i == OP_MTHI) ? HL_HI : HL_LO;
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (count_q == CW'(WIDTH - 1)) begin
            state_q    <= S_DONE;
            din_hi_q   <= res_hi_d;
            din_lo_q   <= res_lo_d;
            hl_write_q <= HL_BOTH;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign din_hi_o   = din_hi_q;
  assign din_lo_o   = din_lo_q;
  assign hl_write_o = hl_write_q;
  assign busy_o     = busy_q;
  assign stall_o    = busy_q | (start_i & is_muldiv(op_i) & (state_q == S_IDLE));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: scoreboard of expected HI/LO writes from a
// reference model, plus a HiLo register model fed by the write port.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic [W-1:0] din_hi, din_lo;
  logic [1:0]   hl_write;
  logic         busy, stall;

  always #10 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .flush_i    (flush),
    .din_hi_o   (din_hi),
    .din_lo_o   (din_lo),
    .hl_write_o (hl_write),
    .busy_o     (busy),
    .stall_o    (stall)
  );

  logic [W-1:0] hi_m = '0, lo_m = '0;
  always @(posedge clk) begin
    if (hl_write[1]) hi_m <= din_hi;
    if (hl_write[0]) lo_m <= din_lo;
  end

  typedef struct packed {
    logic [1:0]   mask;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] exp_hi = '0, exp_lo = '0;
  int           n_cmp = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [63:0]  p;
    logic [W-1:0] ma, mb, q, r;
    logic         sa, sb;
    e = '0;
    case (o)
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        e.mask = HL_BOTH; {e.hi, e.lo} = p;
      end
      OP_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.mask = HL_BOTH; {e.hi, e.lo} = p;
      end
      OP_DIV, OP_DIVU: begin
        sa = (o == OP_DIV) & a[31];
        sb = (o == OP_DIV) & b[31];
        ma = sa ? -a : a;
        mb = sb ? -b : b;
        if (mb == 0) begin q = '1; r = ma; end
        else begin q = ma / mb; r = ma % mb; end
        e.mask = HL_BOTH;
        e.lo   = (sa ^ sb) ? -q : q;
        e.hi   = sa ? -r : r;
      end
      OP_MTHI: begin e.mask = HL_HI; e.hi = a; end
      OP_MTLO: begin e.mask = HL_LO; e.lo = a; end
      default: e.mask = HL_NONE;
    endcase
    return e;
  endfunction

  task automatic check_write();
    exp_t e;
    check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("hl_write", 64'(hl_write), 64'(e.mask));
      if (e.mask[1]) begin check("din_hi", 64'(din_hi), 64'(e.hi)); exp_hi = e.hi; end
      if (e.mask[0]) begin check("din_lo", 64'(din_lo), 64'(e.lo)); exp_lo = e.lo; end
    end
  endtask

  task automatic check_hilo(input string tag);
    check({tag, "_hi"}, 64'(hi_m), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_m), 64'(exp_lo));
  endtask

  task automatic wait_write(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    while (hl_write == HL_NONE && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (busy) busy_cnt++;
  endtask

  task automatic idle_watch(input int n, output int writes);
    writes = 0;
    repeat (n) begin
      @(negedge clk);
      if (hl_write != HL_NONE) writes++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    sb_q.push_back(ref_model(o, a, b));
    #1 check("stall_on_issue", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_write(cyc, busy_cnt);
    check("latency", 64'(cyc), 64'd32);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check_write();
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    check("hl_after", 64'(hl_write), 64'd0);
    check_hilo("hilo");
  endtask

  task automatic mt_pair(input logic [W-1:0] h, input logic [W-1:0] l);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; src_a = h;
    sb_q.push_back(ref_model(OP_MTHI, h, '0));
    #1 check("stall_mthi", 64'(stall), 64'd0);
    @(negedge clk);
    check_write();
    check("busy_mthi", 64'(busy), 64'd0);
    op = OP_MTLO; src_a = l;
    sb_q.push_back(ref_model(OP_MTLO, l, '0));
    @(negedge clk);
    check_write();
    check("busy_mtlo", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check("hl_after_mt", 64'(hl_write), 64'd0);
    check_hilo("hilo_mt");
  endtask

  initial begin
    int cyc, bc, writes;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hl", 64'(hl_write), 64'd0);
    check("rst_din_hi", 64'(din_hi), 64'd0);
    check("rst_din_lo", 64'(din_lo), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU,  32'd7,         32'd0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000);
    run_op(OP_DIVU,  32'd1000,      32'd7);

    mt_pair(32'h1111_1111, 32'h2222_2222);

    // Flush mid-divide must leave HI/LO untouched.
    mt_pair(32'hAAAA_AAAA, 32'hAAAA_AAAA);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hl", 64'(hl_write), 64'd0);
    idle_watch(40, writes);
    check("flush_writes", 64'(writes), 64'd0);
    check_hilo("hilo_flush");
    run_op(OP_MULTU, 32'd3, 32'd4);

    // Flush and start together in IDLE: nothing issues.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    idle_watch(5, writes);
    check("flush_start_writes", 64'(writes), 64'd0);

    // Unknown op code is a no-op.
    @(negedge clk);
    start = 1'b1; op = 3'd7; src_a = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    check("unk_busy", 64'(busy), 64'd0);
    check("unk_hl", 64'(hl_write), 64'd0);

    // Second request while busy is dropped.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
    sb_q.push_back(ref_model(OP_MULTU, 32'd2, 32'd3));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
    #1 check("stall_busy", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_write(cyc, bc);
    check("latency_busy_start", 64'(cyc), 64'd27);
    check_write();
    @(negedge clk);
    check_hilo("hilo_ignore");
    idle_watch(40, writes);
    check("ignored_writes", 64'(writes), 64'd0);
    check("ignored_busy", 64'(busy), 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hl", 64'(hl_write), 64'd0);
    check("midrst_din_hi", 64'(din_hi), 64'd0);
    check("midrst_din_lo", 64'(din_lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    idle_watch(40, writes);
    check("midrst_writes", 64'(writes), 64'd0);
    check_hilo("hilo_midrst");
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
